// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter: video fetch has absolute priority, CPU byte writes are
// posted into a small FIFO and drained in idle slots, CPU byte reads follow all pending writes.
module sram_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_req,
    input  logic [17:0]      v_addr,
    output logic             v_valid,
    output logic [15:0]      v_data,
    input  logic             cpu_wr_stb,
    input  logic [18:0]      cpu_addr,
    input  logic [7:0]       cpu_wdata,
    input  logic             cpu_rd_req,
    output logic             cpu_rd_ack,
    output logic [7:0]       cpu_rd_data,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_full,
    output logic             wr_ovf,
    input  logic [15:0]      sram_dq,
    output logic [15:0]      sram_wdata,
    output logic             sram_wdata_oe,
    output logic [17:0]      sram_addr,
    output logic             sram_oe_n,
    output logic             sram_we_n,
    output logic             sram_lb_n,
    output logic             sram_ub_n
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_VIDEO,
        SLOT_WRITE,
        SLOT_READ
    } slot_t;

    slot_t             r_slot_p1;
    slot_t             w_slot_nxt;
    logic [26:0]       r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_ovf;
    logic              r_rd_lane_p1;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;
    logic [26:0]       w_head;

    assign fifo_count   = r_count;
    assign fifo_full    = (r_count == LP_FULL);
    assign wr_ovf       = r_ovf;
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_fifo_mem[r_rd_ptr];
    assign w_pop        = (w_slot_nxt == SLOT_WRITE);
    assign w_push_ok    = cpu_wr_stb && (!fifo_full || w_pop);
    assign w_drop       = cpu_wr_stb && fifo_full && !w_pop;

    // Slot decision: the slot on the pins (r_slot_p1) is the previous slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_p1 <= SLOT_IDLE;
        end else begin
            r_slot_p1 <= w_slot_nxt;
        end
    end

    // A read also waits out a write strobed in the same cycle, so it cannot overtake it.
    always_comb begin
        w_slot_nxt = SLOT_IDLE;
        if (v_req) begin
            w_slot_nxt = SLOT_VIDEO;
        end else if (!w_fifo_empty && (r_slot_p1 != SLOT_WRITE)) begin
            w_slot_nxt = SLOT_WRITE;
        end else if (w_fifo_empty && cpu_rd_req && !cpu_wr_stb &&
                     (r_slot_p1 != SLOT_READ) && !cpu_rd_ack) begin
            w_slot_nxt = SLOT_READ;
        end
    end

    // Posted-write FIFO
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo_mem[r_wr_ptr] <= {cpu_addr, cpu_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Pin stage (p1)
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr     <= '0;
            sram_wdata    <= '0;
            sram_wdata_oe <= 1'b0;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_lb_n     <= 1'b1;
            sram_ub_n     <= 1'b1;
            r_rd_lane_p1  <= 1'b0;
        end else begin
            case (w_slot_nxt)
                SLOT_VIDEO: begin
                    sram_addr     <= v_addr;
                    sram_oe_n     <= 1'b0;
                    sram_we_n     <= 1'b1;
                    sram_lb_n     <= 1'b0;
                    sram_ub_n     <= 1'b0;
                    sram_wdata_oe <= 1'b0;
                end
                SLOT_WRITE: begin
                    sram_addr     <= w_head[26:9];
                    sram_oe_n     <= 1'b1;
                    sram_we_n     <= 1'b0;
                    sram_lb_n     <= w_head[8];
                    sram_ub_n     <= ~w_head[8];
                    sram_wdata    <= {w_head[7:0], w_head[7:0]};
                    sram_wdata_oe <= 1'b1;
                end
                SLOT_READ: begin
                    sram_addr     <= cpu_addr[18:1];
                    sram_oe_n     <= 1'b0;
                    sram_we_n     <= 1'b1;
                    sram_lb_n     <= 1'b0;
                    sram_ub_n     <= 1'b0;
                    sram_wdata_oe <= 1'b0;
                    r_rd_lane_p1  <= cpu_addr[0];
                end
                default: begin
                    sram_oe_n     <= 1'b1;
                    sram_we_n     <= 1'b1;
                    sram_lb_n     <= 1'b1;
                    sram_ub_n     <= 1'b1;
                    sram_wdata_oe <= 1'b0;
                end
            endcase
        end
    end

    // Data return stage (p2)
    always_ff @(posedge clk) begin
        if (rst) begin
            v_valid     <= 1'b0;
            v_data      <= '0;
            cpu_rd_ack  <= 1'b0;
            cpu_rd_data <= '0;
        end else begin
            v_valid    <= (r_slot_p1 == SLOT_VIDEO);
            cpu_rd_ack <= (r_slot_p1 == SLOT_READ);
            if (r_slot_p1 == SLOT_VIDEO) begin
                v_data <= sram_dq;
            end
            if (r_slot_p1 == SLOT_READ) begin
                cpu_rd_data <= r_rd_lane_p1 ? sram_dq[15:8] : sram_dq[7:0];
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural 256Kx16 async SRAM model.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        v_req;
    logic [17:0] v_addr;
    logic        v_valid;
    logic [15:0] v_data;
    logic        cpu_wr_stb;
    logic [18:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rd_req;
    logic        cpu_rd_ack;
    logic [7:0]  cpu_rd_data;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        wr_ovf;
    logic [15:0] sram_dq;
    logic [15:0] sram_wdata;
    logic        sram_wdata_oe;
    logic [17:0] sram_addr;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_lb_n;
    logic        sram_ub_n;

    logic [15:0] mem [0:262143];
    int          n_cmp;
    int          n_err;

    sram_arbiter #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .v_req(v_req), .v_addr(v_addr), .v_valid(v_valid), .v_data(v_data),
        .cpu_wr_stb(cpu_wr_stb), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rd_req(cpu_rd_req), .cpu_rd_ack(cpu_rd_ack), .cpu_rd_data(cpu_rd_data),
        .fifo_count(fifo_count), .fifo_full(fifo_full), .wr_ovf(wr_ovf),
        .sram_dq(sram_dq), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: combinational read, byte-lane write committed at the end of a we_n=0 cycle.
    assign sram_dq = mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0] = sram_wdata[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] = sram_wdata[15:8];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {we_n, oe_n, lb_n, ub_n, wdata_oe}
    function automatic logic [63:0] ctl();
        return 64'({sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n, sram_wdata_oe});
    endfunction

    function automatic logic [63:0] pins();
        return 64'({sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n, sram_wdata_oe, sram_addr, sram_wdata});
    endfunction

    function automatic logic [63:0] pv(input logic we, input logic oe, input logic lb, input logic ub,
                                       input logic doe, input logic [17:0] a, input logic [15:0] wd);
        return 64'({we, oe, lb, ub, doe, a, wd});
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        v_req = 1'b0;
        v_addr = '0;
        cpu_wr_stb = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_rd_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [18:0] a, input logic [7:0] exp);
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        cpu_addr = a;
        cpu_rd_req = 1'b1;
        while (n < 20 && !got) begin
            tick();
            n++;
            if (cpu_rd_ack) got = 1'b1;
        end
        check_val({tag, "_lat"}, 64'(n), 64'd2);
        check_val({tag, "_data"}, 64'(cpu_rd_data), 64'(exp));
        cpu_rd_req = 1'b0;
        tick();
        check_val({tag, "_once"}, 64'(cpu_rd_ack), 64'd0);
    endtask

    initial begin
        int bad;
        int pulses;
        int first;
        int nwr;
        int nack;
        logic [15:0] last_wd;

        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 262144; i++) mem[i] = 16'(i);
        do_reset();

        check_val("rst_ctl", ctl(), 64'b11110);
        check_val("rst_addr", 64'(sram_addr), 64'd0);
        check_val("rst_wdata", 64'(sram_wdata), 64'd0);
        check_val("rst_outs", 64'({v_valid, v_data, cpu_rd_ack, cpu_rd_data, fifo_count, fifo_full, wr_ovf}), 64'd0);

        // Video burst of 1280 words, data = address
        bad = 0;
        pulses = 0;
        first = -1;
        for (int i = 0; i <= 1281; i++) begin
            if (i < 1280) begin
                v_req = 1'b1;
                v_addr = 18'(i);
            end else begin
                v_req = 1'b0;
            end
            tick();
            if (v_valid) begin
                if (first < 0) first = i;
                if (v_data !== 16'(pulses)) bad++;
                pulses++;
            end else if (i >= 1 && i <= 1280) begin
                bad++;
            end
        end
        check_val("vid_pulses", 64'(pulses), 64'd1280);
        check_val("vid_first", 64'(first), 64'd1);
        check_val("vid_order", 64'(bad), 64'd0);

        // Posted writes during fetch
        nwr = 0;
        for (int i = 0; i < 6; i++) begin
            v_req = 1'b1;
            v_addr = 18'h100 + 18'(i);
            cpu_wr_stb = (i >= 1 && i <= 3);
            cpu_addr = 19'(i);
            cpu_wdata = (i == 1) ? 8'hA1 : (i == 2) ? 8'hB2 : 8'hC3;
            tick();
            if (!sram_we_n) nwr++;
        end
        cpu_wr_stb = 1'b0;
        check_val("pw_count", 64'(fifo_count), 64'd3);
        check_val("pw_no_we", 64'(nwr), 64'd0);
        v_req = 1'b0;
        tick();
        check_val("pw_wr1", pins(), pv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 18'h0, 16'hA1A1));
        check_val("pw_cnt1", 64'(fifo_count), 64'd2);
        tick();
        check_val("pw_gap1", ctl(), 64'b11110);
        tick();
        check_val("pw_wr2", pins(), pv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 18'h1, 16'hB2B2));
        tick();
        check_val("pw_gap2", ctl(), 64'b11110);
        tick();
        check_val("pw_wr3", pins(), pv(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 18'h1, 16'hC3C3));
        check_val("pw_cnt3", 64'(fifo_count), 64'd0);
        tick();

        // Byte-lane reads of the written data
        do_read("rd_ub", 19'h3, 8'hC3);
        do_read("rd_lb", 19'h2, 8'hB2);

        // Read-after-write ordering
        do_reset();
        cpu_wr_stb = 1'b1;
        cpu_addr = 19'h10;
        cpu_wdata = 8'h5A;
        tick();
        cpu_wr_stb = 1'b0;
        cpu_rd_req = 1'b1;
        tick();
        check_val("raw_wr", pins(), pv(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 18'h8, 16'h5A5A));
        tick();
        check_val("raw_rd", 64'({ctl()[4:0], sram_addr}), 64'({5'b10000, 18'h8}));
        tick();
        check_val("raw_ack", 64'({cpu_rd_ack, cpu_rd_data}), 64'({1'b1, 8'h5A}));
        cpu_rd_req = 1'b0;
        tick();
        check_val("raw_ack_drop", 64'(cpu_rd_ack), 64'd0);

        // Overflow with video holding the SRAM
        do_reset();
        v_req = 1'b1;
        v_addr = 18'h200;
        for (int k = 0; k < 5; k++) begin
            cpu_wr_stb = 1'b1;
            cpu_addr = 19'h40 + 19'(k);
            cpu_wdata = 8'h10 + 8'(k);
            tick();
            if (k == 3) check_val("ovf_full4", 64'({fifo_full, wr_ovf}), 64'b10);
        end
        check_val("ovf_set", 64'({wr_ovf, fifo_count}), 64'({1'b1, 3'd4}));
        cpu_wr_stb = 1'b0;
        v_req = 1'b0;
        nwr = 0;
        last_wd = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (!sram_we_n) begin
                nwr++;
                last_wd = sram_wdata;
            end
        end
        check_val("ovf_nwr", 64'(nwr), 64'd4);
        check_val("ovf_last", 64'(last_wd), 64'h1313);
        check_val("ovf_sticky", 64'({wr_ovf, fifo_count}), 64'({1'b1, 3'd0}));

        // Push and pop in the same cycle while full
        do_reset();
        v_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cpu_wr_stb = 1'b1;
            cpu_addr = 19'h60 + 19'(k);
            cpu_wdata = 8'h20 + 8'(k);
            tick();
        end
        v_req = 1'b0;
        cpu_addr = 19'h70;
        cpu_wdata = 8'h77;
        tick();
        cpu_wr_stb = 1'b0;
        check_val("pp_count", 64'({fifo_count, wr_ovf}), 64'({3'd4, 1'b0}));
        check_val("pp_pop", 64'(sram_we_n), 64'd0);
        nwr = 0;
        last_wd = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!sram_we_n) begin
                nwr++;
                last_wd = sram_wdata;
            end
        end
        check_val("pp_nwr", 64'(nwr), 64'd4);
        check_val("pp_last", 64'(last_wd), 64'h7777);

        // Reset with a read in flight and a write queued
        do_reset();
        v_req = 1'b1;
        cpu_wr_stb = 1'b1;
        cpu_addr = 19'h81;
        cpu_wdata = 8'h99;
        tick();
        v_req = 1'b0;
        cpu_wr_stb = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        cpu_addr = 19'h3;
        cpu_rd_req = 1'b1;
        tick();
        check_val("rm_rd_issued", ctl(), 64'b10000);
        rst = 1'b1;
        v_req = 1'b1;
        cpu_wr_stb = 1'b1;
        cpu_addr = 19'h90;
        tick();
        rst = 1'b0;
        v_req = 1'b0;
        cpu_wr_stb = 1'b0;
        cpu_rd_req = 1'b0;
        check_val("rm_fifo", 64'({fifo_count, fifo_full, wr_ovf}), 64'd0);
        check_val("rm_pins", ctl(), 64'b11110);
        nack = 0;
        nwr = 0;
        if (cpu_rd_ack) nack++;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (cpu_rd_ack) nack++;
            if (!sram_we_n) nwr++;
        end
        check_val("rm_no_ack", 64'(nack), 64'd0);
        check_val("rm_no_wr", 64'(nwr), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
